// File: rtl/bus_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bus_ctrl_pkg
// Shared definitions for the multi-channel bus control FSM. The state
// encodings are visible on the status ports, so bus monitors and benches
// decode those ports with these same names.
// Contents:
//   STATE_W  width of the state encoding
//   state_t  IDLE=0, READ=1, WRITE=2, WAIT=3, DONE=4, ERR=5 (6,7 unused)
// ---------------------------------------------------------------------------
package bus_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. It grants the first requester at or
// above the pointer and wraps past the top channel back to channel 0. The FSM
// that owns the pointer registers the result when it accepts a grant.
// Ports:
//   i_req    per-channel request vector
//   i_ptr    channel index with the highest priority this cycle
//   o_gnt    one-hot grant (all zero when nobody requests)
//   o_idx    binary index of the granted channel
//   o_valid  high when some channel is granted
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_CH-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Walk the channels in priority order, starting at the pointer and
    // wrapping. The first requester found wins. Later candidates are
    // ignored once o_valid is set.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] candIdx;
        cand    = 0;
        candIdx = '0;
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            cand    = (int'(i_ptr) + i) % N_CH;
            candIdx = IDX_W'(cand);
            if (!o_valid && i_req[candIdx]) begin
                o_valid        = 1'b1;
                o_idx          = candIdx;
                o_gnt[candIdx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_ctrl_arb_fsm.sv
// ---------------------------------------------------------------------------
// bus_ctrl_arb_fsm
// Multi-channel bus control FSM. It picks a requesting channel round-robin,
// then runs a read or write burst of len+1 beats toward the shared slave.
// Each beat waits for i_ok. If i_ok stays low too long, the burst aborts
// through ERR.
// Ports:
//   i_clk, i_rst     clock; synchronous active-high reset
//   i_req/i_write    per-channel request level and direction (1 = write)
//   i_len            per-channel beats-1, channel k at [k*BURST_W +: BURST_W]
//   i_ok             slave acknowledge for the current beat
//   o_gnt            one-hot grant while a burst is in flight
//   o_bus_rd/wr      strobes, high for the single READ/WRITE cycle of a beat
//   o_beat           0-based index of the current beat
//   o_done/o_err     one-cycle completion / timeout-abort pulses
//   o_stat_current   registered state encoding
//   o_stat_next      combinational next state (IDLE while reset is held)
// ---------------------------------------------------------------------------
module bus_ctrl_arb_fsm
    import bus_ctrl_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int BURST_W = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_CH-1:0]         i_req,
    input  logic [N_CH-1:0]         i_write,
    input  logic [N_CH*BURST_W-1:0] i_len,
    input  logic                    i_ok,
    output logic [N_CH-1:0]         o_gnt,
    output logic                    o_bus_rd,
    output logic                    o_bus_wr,
    output logic [BURST_W-1:0]      o_beat,
    output logic                    o_done,
    output logic                    o_err,
    output logic [STATE_W-1:0]      o_stat_current,
    output logic [STATE_W-1:0]      o_stat_next
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ch_q, ch_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [N_CH-1:0]    gnt_q, gnt_d;
    logic               dir_q, dir_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [BURST_W-1:0] beat_q, beat_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    logic [N_CH-1:0]    gntOut_q;
    logic               rd_q, wr_q, done_q, err_q;

    logic [N_CH-1:0]    arbGnt;
    logic [IDX_W-1:0]   arbIdx;
    logic               arbValid;
    logic [BURST_W-1:0] lenSel;

    rr_arbiter #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req   (i_req),
        .i_ptr   (ptr_q),
        .o_gnt   (arbGnt),
        .o_idx   (arbIdx),
        .o_valid (arbValid)
    );

    // Pick out the length field of the channel the arbiter would grant.
    // The loop uses only constant slice bases. This keeps the selection a
    // plain mux with no variable-width part-select.
    always_comb begin
        lenSel = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (arbIdx == IDX_W'(k)) begin
                lenSel = i_len[k*BURST_W +: BURST_W];
            end
        end
    end

    // Next-state logic for the FSM and its context registers.
    // Channel, direction and length are captured only on the IDLE grant.
    // After that, request-side inputs cannot disturb a burst in flight.
    // In WAIT, an acknowledge is checked before the timeout counter. This
    // lets a late i_ok on the final allowed cycle still complete the beat.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        dir_d   = dir_q;
        len_d   = len_q;
        beat_d  = beat_q;
        tmo_d   = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (arbValid) begin
                    ch_d    = arbIdx;
                    gnt_d   = arbGnt;
                    dir_d   = i_write[arbIdx];
                    len_d   = lenSel;
                    beat_d  = '0;
                    state_d = i_write[arbIdx] ? ST_WRITE : ST_READ;
                end
            end
            ST_READ, ST_WRITE: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_ok) begin
                    if (beat_q == len_q) begin
                        state_d = ST_DONE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = dir_q ? ST_WRITE : ST_READ;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_q == TMO_LAST) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_DONE, ST_ERR: begin
                ptr_d   = (ch_q == IDX_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The single state register of the FSM. The bus-facing outputs are
    // registered here from the next state. They therefore always match the
    // current registered state, and i_ok/i_req have no combinational path to
    // them. Reset clears everything and drops an in-flight burst with no
    // completion pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            ptr_q    <= '0;
            gnt_q    <= '0;
            dir_q    <= 1'b0;
            len_q    <= '0;
            beat_q   <= '0;
            tmo_q    <= '0;
            gntOut_q <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            dir_q    <= dir_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            tmo_q    <= tmo_d;
            gntOut_q <= (state_d == ST_READ || state_d == ST_WRITE ||
                         state_d == ST_WAIT) ? gnt_d : '0;
            rd_q     <= (state_d == ST_READ);
            wr_q     <= (state_d == ST_WRITE);
            done_q   <= (state_d == ST_DONE);
            err_q    <= (state_d == ST_ERR);
        end
    end

    assign o_gnt          = gntOut_q;
    assign o_bus_rd       = rd_q;
    assign o_bus_wr       = wr_q;
    assign o_beat         = beat_q;
    assign o_done         = done_q;
    assign o_err          = err_q;
    assign o_stat_current = state_q;
    assign o_stat_next    = i_rst ? ST_IDLE : state_d;

endmodule
